div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Multi-cycle radix-2 restoring divider with its own sequencing FSM, serving DIV/DIVU for the EX stage.
- EX raises start_i with the operands and stalls the pipeline until ready_o is high.
- It then captures result_o into HI/LO: remainder goes to HI, quotient to LO.
- The block owns all iteration state, so EX stays combinational apart from the start/ready handshake.

Parameters:
- WIDTH, 32, operand width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by EX until the result is consumed.
- annul_i  in  1  abort, e.g. flush or delay-slot cancel.
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  result valid.

Behaviour:
- Reset: state DivFree, ready_o=0, result_o=0, counter=0, internal registers=0. rst_n low mid-operation aborts immediately; no result is produced.
- Operands are latched when start_i is sampled in DivFree. They need not stay stable afterwards.
- Signed mode: operands are converted to magnitudes. Quotient sign = op1[MSB]^op2[MSB]; remainder sign = op1[MSB].
- Sign fix-up happens in the final step. Arithmetic wraps at WIDTH, so 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- DivFree:
  - start_i=1 and annul_i=0 with opdata2_i==0 -> DivByZero.
  - start_i=1 and annul_i=0 with nonzero divisor -> DivOn, counter=0.
  - Otherwise stay in DivFree.
- DivByZero: next edge -> DivEnd with result_o=0 and ready_o=1.
- DivOn, one quotient bit per edge:
  - Shift the partial remainder left and trial-subtract the divisor.
  - Keep the difference if it is non-negative and shift in 1; otherwise keep the old value and shift in 0.
  - counter increments each edge.
  - On the edge where counter==WIDTH: apply sign correction, load result_o, set ready_o=1, go to DivEnd.
- Latency: ready_o rises WIDTH+2 edges after the edge that sampled start_i (34 for WIDTH=32). For divide-by-zero it rises after 2 edges.
- DivEnd: hold result_o and ready_o while start_i=1. When start_i=0, next edge -> DivFree with ready_o=0 and result_o=0.
- annul_i=1 in DivOn, DivByZero or DivEnd -> DivFree on the next edge, ready_o=0, result_o=0.
- annul_i=1 together with start_i=1 in DivFree -> stay in DivFree (annul wins).
- A new start_i is never accepted outside DivFree; a back-to-back DIV needs one idle cycle with start_i=0.
- ready_o and result_o are registered with no combinational path from the inputs.

Optional Feature:
- Macro: DIV_FAST_SMALL_EN.
- Defined: in DivFree with start_i=1, nonzero divisor and |op1| < |op2| (unsigned magnitudes), go directly to DivEnd on the next edge.
  - quotient=0, remainder=opdata1_i unchanged, ready_o after 1 edge.
  - This also covers dividend==0.
- Undefined: every nonzero-divisor request takes the full WIDTH+2 edges.

Decomposition:
- Shared macro file (macro.v):
  - DivFree, DivByZero, DivOn, DivEnd (2-bit encodings 00, 01, 10, 11).
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
- The existing RegBus / DoubleRegBus / ZeroWord definitions are reused.
- One natural sub-module, div_step: combinational shift-and-trial-subtract producing the next partial remainder and the quotient bit. It is instantiated once.

Test Plan:
- DIVU 100/7: start held -> ready_o rises exactly 34 edges after the start edge, result_o=0x00000002_0000000E; drop start_i -> ready_o=0 next edge.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3).
- DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000. DIVU 5/0 -> result_o=0, ready_o after 2 edges.
- annul_i pulsed at iteration 10 of DIVU 1000/3 -> DivFree, ready_o never rises. The next start of 1000/3 yields 0x00000001_0000014D after 34 edges.
- rst_n pulsed low mid-DivOn -> outputs 0 immediately (asynchronous). annul_i+start_i together in DivFree -> no operation starts.
- With DIV_FAST_SMALL_EN: DIVU 3/10 -> ready_o after 1 edge, result_o=0x00000003_00000000. Without the macro -> same value after 34 edges.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// handshake levels and the legacy register-bus widths.
package div_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    // Result-ready levels
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Start request levels
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Register bus widths shared with the rest of the core
    localparam int          RegBus       = 32;
    localparam int          DoubleRegBus = 64;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring-division step: shift the partial remainder left,
// bring in the next dividend bit and trial-subtract the divisor.
import div_ctrl_pkg::*;

module div_step #(
    parameter int WIDTH = RegBus
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; the partial remainder is always below the divisor,
    // so a non-negative difference fits in WIDTH bits and bit WIDTH of the
    // wrapped difference is a reliable borrow flag.
    always_comb begin
        shifted  = {rem, shift_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with its own sequencer.
// EX holds start_i until ready_o is seen; result_o = {remainder, quotient}.
// Optional build macro DIV_FAST_SMALL_EN: when |dividend| < |divisor| the
// result (quotient 0, remainder = dividend) is produced on the start edge.
import div_ctrl_pkg::*;

module div_ctrl #(
    parameter int WIDTH = RegBus,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    // Conditional two's-complement negate; wraps at WIDTH, so the most
    // negative value maps onto itself.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Sequencer state and iteration registers
    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   dvsr_q,   dvsr_d;
    logic               q_neg_q,  q_neg_d;
    logic               r_neg_q,  r_neg_d;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    // Operand views
    logic signed [WIDTH-1:0] op1_s;
    logic signed [WIDTH-1:0] op2_s;
    logic                    op1_neg;
    logic                    op2_neg;
    logic [WIDTH-1:0]        op1_mag;
    logic [WIDTH-1:0]        op2_mag;
    logic                    div_zero;
    logic                    fast_small;
    logic                    accept;

    // Step datapath outputs
    logic [WIDTH-1:0]        rem_step;
    logic                    q_bit;

    assign op1_s    = opdata1_i;
    assign op2_s    = opdata2_i;
    assign op1_neg  = signed_div_i & (op1_s < 0);
    assign op2_neg  = signed_div_i & (op2_s < 0);
    assign op1_mag  = neg_if(opdata1_i, op1_neg);
    assign op2_mag  = neg_if(opdata2_i, op2_neg);
    assign div_zero = (opdata2_i == '0);
    assign accept   = (start_i == DivStart) & ~annul_i;

`ifdef DIV_FAST_SMALL_EN
    assign fast_small = (op1_mag < op2_mag);
`else
    assign fast_small = 1'b0;
`endif

    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .shift_in (quo_q[WIDTH-1]),
        .divisor  (dvsr_q),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    // Next-state and datapath update for every FSM state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_o;
        ready_d  = ready_o;

        case (state_q)
            DivFree: begin
                // Annul wins over a simultaneous start request
                if (accept) begin
                    if (div_zero) begin
                        state_d = DivByZero;
                    end else if (fast_small) begin
                        state_d  = DivEnd;
                        result_d = {opdata1_i, {WIDTH{1'b0}}};
                        ready_d  = DivResultReady;
                    end else begin
                        // Quotient register starts as the dividend magnitude;
                        // its MSB is shifted into the remainder each step.
                        state_d = DivOn;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = op1_mag;
                        dvsr_d  = op2_mag;
                        q_neg_d = op1_neg ^ op2_neg;
                        r_neg_d = op1_neg;
                    end
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    state_d  = DivEnd;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    // All quotient bits done: restore signs and publish
                    state_d  = DivEnd;
                    cnt_d    = '0;
                    result_d = {neg_if(rem_q, r_neg_q), neg_if(quo_q, q_neg_q)};
                    ready_d  = DivResultReady;
                end else begin
                    rem_d = rem_step;
                    quo_d = {quo_q[WIDTH-2:0], q_bit};
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DivEnd: begin
                // Hold the result until EX drops its request
                if (annul_i || (start_i == DivStop)) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end

            default: begin
                state_d  = DivFree;
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    // State, iteration and output registers; reset aborts any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule
